rv32i_gcd_job_ctrl: RTL and testbench

- Host-side job controller wrapped around rv32i_cpu running the GCD firmware.
- Accepts operand pairs over a valid/ready request channel.
- Sequences the core through reset, calc_start and run, and detects completion by watching the core PC reach a halt address.
- Returns the result, a timeout flag and a cycle count over a valid/ready response channel. One job is in flight at a time.

---
 rtl/rv32i_gcd_job_ctrl_pkg.sv | 25 ++
 rtl/rv32i_halt_detector.sv | 41 ++++
 rtl/rv32i_gcd_job_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rv32i_gcd_job_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_gcd_job_ctrl_pkg.sv
// Shared definitions for the GCD job controller.
// Contents:
//   gjc_state_e       - controller state encoding (3-bit)
//   DEFAULT_HALT_PC   - address of the firmware's terminal `j .` loop
//   shortcut_result() - answer for a job with a zero operand (gcd(x,0)=x)
package rv32i_gcd_job_ctrl_pkg;

    typedef enum logic [2:0] {
        GJC_IDLE  = 3'd0,
        GJC_CRST  = 3'd1,
        GJC_START = 3'd2,
        GJC_RUN   = 3'd3,
        GJC_RESP  = 3'd4
    } gjc_state_e;

    localparam logic [31:0] DEFAULT_HALT_PC = 32'h0000_0040;

    // gcd(a,0)=a, gcd(0,b)=b and gcd(0,0) is reported as 0, so an OR
    // covers every zero-operand case without running the core.
    function automatic logic [31:0] shortcut_result(input logic [31:0] a,
                                                    input logic [31:0] b);
        return a | b;
    endfunction

endpackage

// File: rtl/rv32i_halt_detector.sv
// Consecutive-match halt detector.
// Counts consecutive cycles in which pc equals halt_pc; any other PC
// clears the count. halted is asserted in the cycle that supplies the
// HALT_CONFIRM-th consecutive match, so the caller can act on it directly.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   clr          - synchronous clear of the match counter
//   pc           - observed program counter
//   halt_pc      - address to match
//   halted       - HALT_CONFIRM consecutive matches seen (this cycle included)
module rv32i_halt_detector #(
    parameter int HALT_CONFIRM = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [31:0] pc,
    input  logic [31:0] halt_pc,
    output logic        halted
);

    localparam int HW = $clog2(HALT_CONFIRM + 1);

    logic [HW-1:0] match_cnt;
    logic          match;

    assign match  = (pc == halt_pc);
    assign halted = match && (match_cnt == HW'(HALT_CONFIRM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (clr || !match) begin
            match_cnt <= '0;
        end else if (!halted) begin
            // Saturate once confirmed; the controller leaves RUN anyway.
            match_cnt <= match_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/rv32i_gcd_job_ctrl.sv
// Host-side job controller for an rv32i core running GCD firmware.
// One job in flight: accept (a,b), hold the core in reset for RST_CYCLES,
// pulse calc_start for one cycle, run until the core PC sits at HALT_PC for
// HALT_CONFIRM consecutive cycles (or MAX_CYCLES elapse), then return the
// result. Operand pairs containing a zero are answered without the core.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid, once raised, is held with its payload stable until that edge.
// req_ready is high only in IDLE; rsp_valid is high only in RESP, and IDLE
// is entered the cycle after the response transfer, so the two never overlap.
//
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   req_valid/req_ready/req_a/req_b     - job request channel
//   rsp_valid/rsp_ready/rsp_result/
//   rsp_timeout/rsp_cycles              - job response channel
//   core_rst_n, calc_start, gcd_a, gcd_b - drives to the core
//   core_pc, gcd_result                 - observed from the core
// All outputs are registered.
module rv32i_gcd_job_ctrl
    import rv32i_gcd_job_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_PC      = DEFAULT_HALT_PC,
    parameter int          RST_CYCLES   = 2,
    parameter int          HALT_CONFIRM = 2,
    parameter int          MAX_CYCLES   = 4096,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             core_rst_n,
    output logic             calc_start,
    output logic [31:0]      gcd_a,
    output logic [31:0]      gcd_b,
    input  logic [31:0]      core_pc,
    input  logic [31:0]      gcd_result
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    gjc_state_e       state, state_next;
    logic [RW-1:0]    rst_cnt, rst_cnt_next;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_next;
    logic [31:0]      gcd_a_next, gcd_b_next, rsp_result_next;
    logic             rsp_timeout_next;
    logic [CNT_W-1:0] rsp_cycles_next;
    logic             halted;

    // The match counter only runs in RUN, so it is zero on the first RUN cycle.
    rv32i_halt_detector #(
        .HALT_CONFIRM (HALT_CONFIRM)
    ) u_halt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != GJC_RUN),
        .pc      (core_pc),
        .halt_pc (HALT_PC),
        .halted  (halted)
    );

    always_comb begin
        state_next       = state;
        rst_cnt_next     = rst_cnt;
        cyc_cnt_next     = cyc_cnt;
        gcd_a_next       = gcd_a;
        gcd_b_next       = gcd_b;
        rsp_result_next  = rsp_result;
        rsp_timeout_next = rsp_timeout;
        rsp_cycles_next  = rsp_cycles;

        case (state)
            GJC_IDLE: begin
                if (req_valid && req_ready) begin
                    gcd_a_next = req_a;
                    gcd_b_next = req_b;
                    if (req_a == 32'd0 || req_b == 32'd0) begin
                        state_next       = GJC_RESP;
                        rsp_result_next  = shortcut_result(req_a, req_b);
                        rsp_cycles_next  = '0;
                        rsp_timeout_next = 1'b0;
                    end else begin
                        state_next   = GJC_CRST;
                        rst_cnt_next = '0;
                    end
                end
            end
            GJC_CRST: begin
                if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                    state_next = GJC_START;
                end else begin
                    rst_cnt_next = rst_cnt + RW'(1);
                end
            end
            GJC_START: begin
                state_next   = GJC_RUN;
                cyc_cnt_next = '0;
            end
            GJC_RUN: begin
                // Count includes the current cycle: first RUN cycle reports 1.
                cyc_cnt_next = cyc_cnt + CNT_W'(1);
                if (halted) begin
                    state_next       = GJC_RESP;
                    rsp_result_next  = gcd_result;
                    rsp_timeout_next = 1'b0;
                    rsp_cycles_next  = cyc_cnt_next;
                end else if (cyc_cnt_next == CNT_W'(MAX_CYCLES)) begin
                    state_next       = GJC_RESP;
                    rsp_result_next  = 32'd0;
                    rsp_timeout_next = 1'b1;
                    rsp_cycles_next  = cyc_cnt_next;
                end
            end
            GJC_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = GJC_IDLE;
                end
            end
            default: begin
                state_next = GJC_IDLE;
            end
        endcase
    end

    // Control outputs are decoded from the next state and registered, so
    // they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GJC_IDLE;
            rst_cnt     <= '0;
            cyc_cnt     <= '0;
            gcd_a       <= '0;
            gcd_b       <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            rsp_cycles  <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            core_rst_n  <= 1'b0;
            calc_start  <= 1'b0;
        end else begin
            state       <= state_next;
            rst_cnt     <= rst_cnt_next;
            cyc_cnt     <= cyc_cnt_next;
            gcd_a       <= gcd_a_next;
            gcd_b       <= gcd_b_next;
            rsp_result  <= rsp_result_next;
            rsp_timeout <= rsp_timeout_next;
            rsp_cycles  <= rsp_cycles_next;
            req_ready   <= (state_next == GJC_IDLE);
            rsp_valid   <= (state_next == GJC_RESP);
            core_rst_n  <= (state_next == GJC_START) || (state_next == GJC_RUN);
            calc_start  <= (state_next == GJC_START);
        end
    end

endmodule

// File: tb/tb_rv32i_gcd_job_ctrl.sv
// Directed testbench for rv32i_gcd_job_ctrl with a behavioural core stub.
// Stub modes: 0 = subtractive GCD (one step per cycle, then parks at HALT_PC),
// 1 = PC never reaches HALT_PC, 2 = scripted PC with a single early touch.
module tb_rv32i_gcd_job_ctrl;

    localparam logic [31:0] HALT_PC      = 32'h0000_0040;
    localparam int          RST_CYCLES   = 2;
    localparam int          HALT_CONFIRM = 2;
    localparam int          MAX_CYCLES   = 64;
    localparam int          CNT_W        = 16;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_timeout;
    logic [CNT_W-1:0] rsp_cycles;
    logic             core_rst_n;
    logic             calc_start;
    logic [31:0]      gcd_a;
    logic [31:0]      gcd_b;
    logic [31:0]      core_pc;
    logic [31:0]      gcd_result;

    rv32i_gcd_job_ctrl #(
        .HALT_PC      (HALT_PC),
        .RST_CYCLES   (RST_CYCLES),
        .HALT_CONFIRM (HALT_CONFIRM),
        .MAX_CYCLES   (MAX_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .rsp_cycles  (rsp_cycles),
        .core_rst_n  (core_rst_n),
        .calc_start  (calc_start),
        .gcd_a       (gcd_a),
        .gcd_b       (gcd_b),
        .core_pc     (core_pc),
        .gcd_result  (gcd_result)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core stub ----------------
    int          core_mode;
    logic [31:0] x_q, y_q, pc_q, res_q;
    int          k;

    always @(posedge clk) begin
        if (!core_rst_n) begin
            pc_q  <= 32'd0;
            x_q   <= 32'd0;
            y_q   <= 32'd0;
            res_q <= 32'd0;
            k     <= 0;
        end else if (calc_start) begin
            x_q  <= gcd_a;
            y_q  <= gcd_b;
            pc_q <= 32'h4;
            k    <= 1;
        end else if (k != 0) begin
            k <= k + 1;
            case (core_mode)
                0: begin
                    if (x_q == y_q) begin
                        pc_q  <= HALT_PC;
                        res_q <= x_q;
                    end else if (x_q > y_q) begin
                        x_q  <= x_q - y_q;
                        pc_q <= 32'h10;
                    end else begin
                        y_q  <= y_q - x_q;
                        pc_q <= 32'h14;
                    end
                end
                1: pc_q <= 32'h8;
                default: res_q <= 32'h1234;
            endcase
        end
    end

    // Scripted mode: HALT_PC on RUN cycle 3 only, then from RUN cycle 6 on.
    assign core_pc    = (core_mode == 2) ? (((k == 3) || (k >= 6)) ? HALT_PC : 32'h20) : pc_q;
    assign gcd_result = res_q;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one job: request, observe the sequence, hold rsp_ready low for
    // 'hold' cycles, then take the response. Result is checked against exp_q.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int hold,
                           output int lat, output int calc_first, output int calc_cnt,
                           output int rst_hi_early, output logic to,
                           output logic [CNT_W-1:0] cyc);
        int          n;
        logic [31:0] res;
        logic [31:0] exp_res;
        exp_res = exp_q.pop_front();
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        // Scramble the request bus: the latched operands must not follow it.
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        lat = 0; calc_first = 0; calc_cnt = 0; rst_hi_early = 0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (calc_start) begin
                calc_cnt++;
                if (calc_first == 0) calc_first = n;
            end
            if (core_rst_n && calc_first == 0) rst_hi_early++;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check("rsp_valid_wait", 32'd0, 32'd1);
        res = rsp_result;
        to  = rsp_timeout;
        cyc = rsp_cycles;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", rsp_result, exp_res);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_req_ready", 32'(req_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("result", res, exp_res);
    endtask

    // ---------------- stimulus ----------------
    int               lat, cfirst, ccnt, rhi, n, seen;
    logic             to;
    logic [CNT_W-1:0] cyc;
    logic [31:0]      sc_tab [3][3];

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        core_mode = 0; checks = 0; errors = 0;
        sc_tab = '{'{32'd0, 32'd7, 32'd7}, '{32'd9, 32'd0, 32'd9}, '{32'd0, 32'd0, 32'd0}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_calc_start", 32'(calc_start), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
        check("rst_gcd_a", gcd_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: gcd(48,18) through the core
        exp_q.push_back(32'd6);
        run_job(32'd48, 32'd18, 0, lat, cfirst, ccnt, rhi, to, cyc);
        check("t1_calc_first", 32'(cfirst), 32'd3);
        check("t1_calc_cnt", 32'(ccnt), 32'd1);
        check("t1_rst_hi_early", 32'(rhi), 32'd0);
        check("t1_latency", 32'(lat), 32'd11);
        check("t1_timeout", 32'(to), 32'd0);
        check("t1_cycles", 32'(cyc), 32'd7);

        // 2: zero-operand shortcuts
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(sc_tab[i][2]);
            run_job(sc_tab[i][0], sc_tab[i][1], 0, lat, cfirst, ccnt, rhi, to, cyc);
            check("t2_latency", 32'(lat), 32'd1);
            check("t2_calc_cnt", 32'(ccnt), 32'd0);
            check("t2_core_rst_hi", 32'(rhi), 32'd0);
            check("t2_cycles", 32'(cyc), 32'd0);
            check("t2_timeout", 32'(to), 32'd0);
        end

        // 3: core never halts -> timeout
        core_mode = 1;
        exp_q.push_back(32'd0);
        run_job(32'd5, 32'd3, 0, lat, cfirst, ccnt, rhi, to, cyc);
        check("t3_timeout", 32'(to), 32'd1);
        check("t3_cycles", 32'(cyc), 32'd64);
        check("t3_latency", 32'(lat), 32'd68);

        // 4: single early touch of HALT_PC must not count
        core_mode = 2;
        exp_q.push_back(32'h1234);
        run_job(32'd3, 32'd4, 0, lat, cfirst, ccnt, rhi, to, cyc);
        check("t4_cycles", 32'(cyc), 32'd7);
        check("t4_timeout", 32'(to), 32'd0);
        check("t4_latency", 32'(lat), 32'd11);

        // 5: response back-pressure, then back-to-back job
        core_mode = 0;
        exp_q.push_back(32'd7);
        run_job(32'd21, 32'd14, 5, lat, cfirst, ccnt, rhi, to, cyc);
        check("t5a_cycles", 32'(cyc), 32'd5);
        check("t5a_latency", 32'(lat), 32'd9);
        exp_q.push_back(32'd25);
        run_job(32'd100, 32'd75, 0, lat, cfirst, ccnt, rhi, to, cyc);
        check("t5b_cycles", 32'(cyc), 32'd6);
        check("t5b_latency", 32'(lat), 32'd10);

        // 6: reset in the middle of RUN
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'd48; req_b = 32'd18;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!core_rst_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_run", 32'(core_rst_n), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_req_ready", 32'(req_ready), 32'd0);
        check("t6_core_rst_n", 32'(core_rst_n), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_calc_start", 32'(calc_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", 32'(seen), 32'd0);
        exp_q.push_back(32'd6);
        run_job(32'd48, 32'd18, 0, lat, cfirst, ccnt, rhi, to, cyc);
        check("t6_cycles", 32'(cyc), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
